rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 datapath selector between four requesters.
- Grants exactly one requester at a time and holds the grant while its request stays high, up to MAX_HOLD cycles.
- Drives the 2-bit select and the selected data word to the downstream consumer.
- Sits between four independent producers and a single shared sink.

---
 rtl/rr_mux_arbiter_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 30 +++
 rtl/rr_mux_arbiter.sv | 117 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants for the round-robin 4:1 mux arbiter: state encodings,
// requester count, select width and a one-hot helper.
package rr_mux_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int HOLD_W = 8;

    typedef logic [1:0] state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority pick: first set request scanning ptr, ptr+1, ... modulo 4.
module rr_priority_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign cand_idx[gi] = ptr + SEL_W'(gi);
            assign rot[gi]      = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the candidate nearest to ptr wins.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) idx = cand_idx[k];
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data selector between four requesters,
// with an optional per-grant hold limit that forces re-arbitration.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [N_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

    state_t             state_reg,    state_next;
    logic [N_REQ-1:0]   gnt_reg,      gnt_next;
    logic [SEL_W-1:0]   sel_reg,      sel_next;
    logic [SEL_W-1:0]   ptr_reg,      ptr_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               holder_req;
    logic               timeout;
    logic [DATA_W-1:0]  din_arr [N_REQ];

    rr_priority_pick u_pick (
        .req (req),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign holder_req = req[sel_reg];
    assign timeout    = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            sel_reg      <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            sel_reg      <= sel_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        sel_next      = sel_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next    = ST_GRANT;
                    sel_next      = pick_idx;
                    gnt_next      = onehot(pick_idx);
                    hold_cnt_next = HOLD_W'(1);
                    ptr_next      = pick_idx + SEL_W'(1);
                end
            end
            ST_GRANT: begin
                // Release and timeout both re-arbitrate on the same edge;
                // after a timeout ptr = sel+1 puts the holder last.
                if ((!holder_req && pick_any) || (holder_req && timeout)) begin
                    state_next    = ST_GRANT;
                    sel_next      = pick_idx;
                    gnt_next      = onehot(pick_idx);
                    hold_cnt_next = HOLD_W'(1);
                    ptr_next      = pick_idx + SEL_W'(1);
                end else if (!holder_req) begin
                    state_next    = ST_IDLE;
                    gnt_next      = '0;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg != HOLD_SAT) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            default: begin
                state_next    = ST_IDLE;
                gnt_next      = '0;
                hold_cnt_next = '0;
            end
        endcase
    end

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;

    assign busy       = (state_reg == ST_GRANT);
    assign gnt        = gnt_reg;
    assign sel        = sel_reg;
    assign dout_valid = busy & holder_req;
    assign dout       = dout_valid ? din_arr[sel_reg] : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench: two arbiters (hold limit 4 and unlimited) checked against
// a behavioural round-robin model before and after every clock edge.
module tb_rr_mux_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] dout;
        logic       dv;
        logic       busy;
        logic [7:0] hold;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [7:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] dout_a, dout_b;
    logic       dv_a, dv_b, busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    bit force_a5 = 1'b0;

    // Model state per instance: 0 = MAX_HOLD 4, 1 = MAX_HOLD 0
    int m_busy [2];
    int m_sel  [2];
    int m_ptr  [2];
    int m_hold [2];
    int m_lim  [2] = '{4, 0};

    obs_t q_a[$];
    obs_t q_b[$];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt_a), .sel(sel_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a)
    );

    rr_mux_arbiter #(.DATA_W(8), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt_b), .sel(sel_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_sel[i] = 0; m_ptr[i] = 0; m_hold[i] = 0;
        end
    endfunction

    function automatic void model_grant(input int i, input int w);
        m_busy[i] = 1;
        m_sel[i]  = w;
        m_hold[i] = 1;
        m_ptr[i]  = (w + 1) % 4;
    endfunction

    function automatic void model_step(input int i, input logic [3:0] r);
        int w;
        w = pick(r, m_ptr[i]);
        if (m_busy[i] == 0) begin
            if (w >= 0) model_grant(i, w);
        end else if (!r[m_sel[i]]) begin
            if (w >= 0) model_grant(i, w);
            else begin
                m_busy[i] = 0;
                m_hold[i] = 0;
            end
        end else if (m_lim[i] != 0 && m_hold[i] == m_lim[i]) begin
            model_grant(i, w);
        end else if (m_hold[i] < 255) begin
            m_hold[i] = m_hold[i] + 1;
        end
    endfunction

    function automatic obs_t model_out(input int i, input logic [3:0] r);
        obs_t o;
        logic [7:0] d [4];
        d[0] = din0; d[1] = din1; d[2] = din2; d[3] = din3;
        o.busy = (m_busy[i] != 0);
        o.sel  = 2'(m_sel[i]);
        o.gnt  = o.busy ? (4'b0001 << m_sel[i]) : 4'b0000;
        o.dv   = o.busy && r[m_sel[i]];
        o.dout = o.dv ? d[m_sel[i]] : 8'h00;
        o.hold = 8'(m_hold[i]);
        return o;
    endfunction

    function automatic obs_t dut_out(input int i);
        obs_t o;
        if (i == 0) o = '{gnt: gnt_a, sel: sel_a, dout: dout_a, dv: dv_a, busy: busy_a,
                          hold: dut_a.hold_cnt_reg};
        else        o = '{gnt: gnt_b, sel: sel_b, dout: dout_b, dv: dv_b, busy: busy_b,
                          hold: dut_b.hold_cnt_reg};
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t req=%b got gnt=%b sel=%0d dout=%h dv=%b busy=%b hold=%0d want gnt=%b sel=%0d dout=%h dv=%b busy=%b hold=%0d",
                     name, $time, req, act.gnt, act.sel, act.dout, act.dv, act.busy, act.hold,
                     exp.gnt, exp.sel, exp.dout, exp.dv, exp.busy, exp.hold);
        end else begin
            $display("ok   %s t=%0t req=%b gnt=%b sel=%0d dout=%h dv=%b busy=%b hold=%0d",
                     name, $time, req, act.gnt, act.sel, act.dout, act.dv, act.busy, act.hold);
        end
    endtask

    // One transaction per negedge: expectation before the edge, then after it.
    task automatic drive(input logic [3:0] r);
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        din0  = 8'($urandom);
        din1  = 8'($urandom);
        din2  = force_a5 ? 8'hA5 : 8'($urandom);
        din3  = 8'($urandom);
        q_a.push_back(model_out(0, r));
        q_b.push_back(model_out(1, r));
        model_step(0, r);
        model_step(1, r);
        q_a.push_back(model_out(0, r));
        q_b.push_back(model_out(1, r));
    endtask

    task automatic check_reset_state(input string name);
        obs_t zero;
        zero = '0;
        compare({name, "_a"}, dut_out(0), zero);
        compare({name, "_b"}, dut_out(1), zero);
    endtask

    // Assert reset between edges and check outputs clear with no edge.
    task automatic mid_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_reset");
        model_reset();
        @(posedge clk);
    endtask

    // Monitor: pops and compares at negedge+1 and posedge+1.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (q_a.size() > 0) compare("pre_a", dut_out(0), q_a.pop_front());
            if (q_b.size() > 0) compare("pre_b", dut_out(1), q_b.pop_front());
            @(posedge clk);
            #1;
            if (q_a.size() > 0) compare("post_a", dut_out(0), q_a.pop_front());
            if (q_b.size() > 0) compare("post_b", dut_out(1), q_b.pop_front());
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_state("reset");

        // Rotation through all four with hold limit 4
        repeat (20) drive(4'b1111);

        // Single requester keeps the grant across hold-limit wraps
        force_a5 = 1'b1;
        repeat (10) drive(4'b0100);
        force_a5 = 1'b0;

        // Requester 1 granted, then drops while requester 3 rises
        repeat (2) drive(4'b0010);
        repeat (2) drive(4'b1000);

        // Requester 0 granted, all drop, then 0011 goes to 1 first
        repeat (2) drive(4'b0001);
        repeat (2) drive(4'b0000);
        repeat (3) drive(4'b0011);

        // Mid-grant asynchronous reset while 2 holds the grant
        repeat (3) drive(4'b0100);
        mid_reset();
        repeat (3) drive(4'b0100);

        // Long hold: unlimited instance saturates at 255
        mid_reset();
        repeat (300) drive(4'b0011);

        // Random traffic with occasional resets
        for (int n = 0; n < 240; n++) begin
            if (n % 60 == 59) mid_reset();
            else drive(4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #3;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
